// File: rtl/stream_arb_mux.sv
// stream_arb_mux
//   Parametrised N:1 registered stream multiplexer with valid/ready
//   handshaking. Each cycle at most one producer channel is granted. The
//   winner comes from a run-time mode: fixed priority (highest index),
//   round-robin, or forced select. The accepted word appears on the
//   registered output one cycle later.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    packed channel data, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   mode       00/11 fixed priority, 01 round-robin, 10 forced select
//   sel        channel index used in forced-select mode (saturates at N-1)
//   out_data   registered data of the last accepted word
//   out_src    registered source channel of the last accepted word
//   out_valid  registered valid
//   out_ready  consumer ready
module stream_arb_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [1:0]         mode,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [SW-1:0]    rr_ptr;
    logic             load;
    logic             grant_ok;
    logic [SW-1:0]    grant_idx;
    logic [SW-1:0]    rr_idx;
    logic [WIDTH-1:0] grant_data;

    // The output register may take a new word when empty or draining this cycle.
    assign load = !out_valid || out_ready;

    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        rr_idx    = '0;
        case (mode)
            2'b01: begin
                // Walk N channels starting just after the last source, with wrap.
                rr_idx = (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
                for (int unsigned k = 0; k < N; k++) begin
                    if (!grant_ok && in_valid[rr_idx]) begin
                        grant_ok  = 1'b1;
                        grant_idx = rr_idx;
                    end
                    rr_idx = (rr_idx == LAST) ? '0 : rr_idx + 1'b1;
                end
            end
            2'b10: begin
                grant_idx = (sel > LAST) ? LAST : sel;
                grant_ok  = in_valid[grant_idx];
            end
            default: begin
                // Later indices overwrite earlier ones: highest valid wins.
                for (int unsigned i = 0; i < N; i++) begin
                    if (in_valid[i]) begin
                        grant_ok  = 1'b1;
                        grant_idx = SW'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SW'(i) == grant_idx) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!reset && load && grant_ok) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= LAST;
        end else if (load) begin
            if (grant_ok) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_src   <= grant_idx;
                rr_ptr    <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux
//   Directed bench for stream_arb_mux: a 4-channel instance exercises reset,
//   round-robin order, fixed priority, forced select, backpressure, mode
//   switching and mid-stream reset; a 3-channel instance checks saturation of
//   an out-of-range sel.
module tb_stream_arb_mux;

    logic        clk;
    logic        reset;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_src3;
    logic        out_valid3;
    logic        out_ready3;

    int n_checks;
    int n_fail;

    stream_arb_mux #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_arb_mux #(.WIDTH(8), .N(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    logic [1:0] rr_exp [5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rr_exp    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        mode      = 2'b00;
        sel       = '0;
        out_ready = 1'b0;
        in_data3  = '0;
        in_valid3 = '0;
        mode3     = 2'b10;
        sel3      = 2'd3;
        out_ready3 = 1'b1;

        // Reset state; in_ready must stay low even with requests pending.
        tick();
        tick();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);

        // Round-robin, all valid: grants 0,1,2,3,0 one per cycle.
        reset = 1'b0;
        mode  = 2'b01;
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << rr_exp[k]));
            tick();
            check("rr_out_valid", 32'(out_valid), 32'h1);
            check("rr_out_src", 32'(out_src), 32'(rr_exp[k]));
            check("rr_out_data", 32'(out_data), 32'(8'hA0 + 8'(rr_exp[k])));
        end

        // Fixed priority: highest valid index wins.
        mode     = 2'b00;
        in_valid = 4'b0110;
        set_data(8'h00, 8'h11, 8'h22, 8'h33);
        #1;
        check("fp_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check("fp_out_data", 32'(out_data), 32'h22);
        check("fp_out_src", 32'(out_src), 32'h2);

        // Forced select of an idle channel: no grant, output drains, data holds.
        mode     = 2'b10;
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        check("fs_none_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("fs_none_out_valid", 32'(out_valid), 32'h0);
        check("fs_none_out_data", 32'(out_data), 32'h22);
        check("fs_none_out_src", 32'(out_src), 32'h2);
        sel = 2'd0;
        #1;
        check("fs_sel0_in_ready", 32'(in_ready), 32'b0001);

        // Backpressure: hold 0x5A for 3 cycles, then drain and fill on one edge.
        mode     = 2'b00;
        in_valid = 4'b0001;
        set_data(8'h5A, 8'h00, 8'h00, 8'h00);
        tick();
        check("bp_load_data", 32'(out_data), 32'h5A);
        out_ready = 1'b0;
        set_data(8'h77, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp_hold_data", 32'(out_data), 32'h5A);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        check("bp_new_data", 32'(out_data), 32'h77);
        check("bp_new_valid", 32'(out_valid), 32'h1);

        // Mode switch: ch3 wins in fixed priority, round-robin then gives 0,1.
        in_valid = 4'hF;
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        check("ms_fp_ready", 32'(in_ready), 32'b1000);
        tick();
        check("ms_fp_src", 32'(out_src), 32'h3);
        mode = 2'b01;
        #1;
        check("ms_rr0_ready", 32'(in_ready), 32'b0001);
        tick();
        check("ms_rr0_src", 32'(out_src), 32'h0);
        check("ms_rr1_ready", 32'(in_ready), 32'b0010);
        tick();
        check("ms_rr1_src", 32'(out_src), 32'h1);

        // Mode 11 behaves as fixed priority.
        mode = 2'b11;
        #1;
        check("m11_in_ready", 32'(in_ready), 32'b1000);

        // Reset mid-stream while stalled: word dropped, rr_ptr back to N-1.
        mode      = 2'b01;
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'h0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        check("mr_out_valid", 32'(out_valid), 32'h0);
        check("mr_out_data", 32'(out_data), 32'h0);
        check("mr_out_src", 32'(out_src), 32'h0);
        #1;
        check("mr_rr_restart", 32'(in_ready), 32'b0001);

        // N=3: sel=3 saturates to channel 2; channel 2 idle means no grant.
        in_data3  = {8'hC2, 8'hC1, 8'hC0};
        in_valid3 = 3'b111;
        #1;
        check("n3_sat_ready", 32'(in_ready3), 32'b100);
        tick();
        check("n3_sat_src", 32'(out_src3), 32'h2);
        check("n3_sat_data", 32'(out_data3), 32'hC2);
        in_valid3 = 3'b011;
        #1;
        check("n3_sat_idle", 32'(in_ready3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
